bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock.
- Sits directly upstream of the hexadecimal seven-segment decoders. Each 4-bit nibble of oBCD drives one decoder's digit input.
- Turns counters, scores and timers into decimal digits for the LED displays.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 137 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helper for the binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    localparam int BCD_NIBBLE_W = 4;

    // Minimum decimal digits for an unsigned bin_w-bit value: ceil(bin_w * log10(2)),
    // evaluated with a fixed-point log10(2) = 0.30103.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction (add 3 when the digit is 5 or more)
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] in_nib,
    output logic [BCD_NIBBLE_W-1:0] out_nib
);

    // Digits 5..9 become 8..12, so the following left shift carries into the next digit.
    always_comb begin
        out_nib = (in_nib >= 4'd5) ? in_nib + 4'd3 : in_nib;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble converter, one bit per clock; BCDCONV_LZB_EN adds leading-zero blanking
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                           iClk,
    input  logic                           iRst_n,
    input  logic                           iStart,
    input  logic [BIN_W-1:0]               iBin,
    output logic                           oBusy,
    output logic                           oDone,
    output logic [BCD_NIBBLE_W*DIGITS-1:0] oBCD
`ifdef BCDCONV_LZB_EN
    ,
    output logic [DIGITS-1:0]              oBlank
`endif
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Refuse to build a converter that cannot hold the largest input value.
    if (DIGITS < min_digits(BIN_W)) begin : g_digits_too_small
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    bcd_state_e        state_q, state_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              done_q, done_d;
    logic [BCD_W-1:0]  scratch_corr;

`ifdef BCDCONV_LZB_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_calc;
    logic              upper_zero;
`endif

    // One correction unit per digit of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_nib  (scratch_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .out_nib (scratch_corr[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

`ifdef BCDCONV_LZB_EN
    // A digit is blanked when it and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero    = upper_zero && (scratch_q[k*BCD_NIBBLE_W +: BCD_NIBBLE_W] == '0);
            blank_calc[k] = upper_zero;
        end
    end
`endif

    // Next-state and datapath: load in IDLE, correct-then-shift in SHIFT, publish in DONE.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
`ifdef BCDCONV_LZB_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    shift_d   = iBin;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = (scratch_corr << 1) | BCD_W'(shift_q[BIN_W-1]);
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
`ifdef BCDCONV_LZB_EN
                blank_d = blank_calc;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
`ifdef BCDCONV_LZB_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
`ifdef BCDCONV_LZB_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign oBusy = (state_q != IDLE);
    assign oDone = done_q;
    assign oBCD  = bcd_q;
`ifdef BCDCONV_LZB_EN
    assign oBlank = blank_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq (vector table, corner sequences, random vs model)
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
`ifdef BCDCONV_LZB_EN
    logic [4:0]  blank;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iStart (start),
        .iBin   (bin),
        .oBusy  (busy),
        .oDone  (done),
        .oBCD   (bcd)
`ifdef BCDCONV_LZB_EN
        ,
        .oBlank (blank)
`endif
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] exp_bcd;
        logic [4:0]  exp_blank;
        bit          change;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits from plain integer division.
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit k (k >= 1) is blank exactly when the value is below 10^k.
    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] r;
        int p;
        r = '0;
        p = 10;
        for (int k = 1; k < 5; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic run_conv(input logic [15:0] v, input bit change,
                            output logic [19:0] res, output logic [4:0] blk,
                            output int lat, output int busy_cnt, output int done_cnt);
        res = '0; blk = '0; lat = -1; busy_cnt = 0; done_cnt = 0;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (change) bin = 16'd999;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = c;
                    res = bcd;
`ifdef BCDCONV_LZB_EN
                    blk = blank;
`endif
                end
            end
        end
    endtask

    initial begin
        logic [19:0] res;
        logic [4:0]  blk;
        logic [19:0] held;
        int lat, bcnt, dcnt;
        int t[$];
        int v;

        vecs[0] = '{16'd0,     20'h00000, 5'b11110, 1'b0};
        vecs[1] = '{16'hFFFF,  20'h65535, 5'b00000, 1'b0};
        vecs[2] = '{16'h3039,  20'h12345, 5'b00000, 1'b1};
        vecs[3] = '{16'd42,    20'h00042, 5'b11100, 1'b0};
        vecs[4] = '{16'd10000, 20'h10000, 5'b00000, 1'b0};
        vecs[5] = '{16'd9999,  20'h09999, 5'b10000, 1'b0};
        vecs[6] = '{16'd1,     20'h00001, 5'b11110, 1'b0};

        rst_n = 1'b0; start = 1'b0; bin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
`ifdef BCDCONV_LZB_EN
        check("reset_blank", 32'(blank), 32'h0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].bin, vecs[i].change, res, blk, lat, bcnt, dcnt);
            check($sformatf("vec%0d_bcd", i), 32'(res), 32'(vecs[i].exp_bcd));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd17);
            check($sformatf("vec%0d_done_count", i), 32'(dcnt), 32'd1);
`ifdef BCDCONV_LZB_EN
            check($sformatf("vec%0d_blank", i), 32'(blk), 32'(vecs[i].exp_blank));
`endif
        end

        // Start pulses while busy are ignored.
        @(negedge clk);
        bin = 16'd321; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = (c == 3 || c == 10);
            if (done) dcnt++;
        end
        start = 1'b0;
        check("busy_start_done_count", 32'(dcnt), 32'd1);
        check("busy_start_bcd", 32'(bcd), 32'h00321);

        // Held start: one result every 18 cycles.
        @(negedge clk);
        bin = 16'd777; start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) t.push_back(c);
        end
        start = 1'b0;
        check("hold_done_count", 32'(t.size()), 32'd3);
        if (t.size() >= 3) begin
            check("hold_interval0", 32'(t[1] - t[0]), 32'd18);
            check("hold_interval1", 32'(t[2] - t[1]), 32'd18);
        end
        check("hold_bcd", 32'(bcd), 32'h00777);
        for (int c = 0; c < 25 && busy; c++) @(negedge clk);
        check("hold_idle", 32'(busy), 32'h0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin = 16'd54321; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_bcd", 32'(bcd), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midreset_no_done", 32'(dcnt), 32'd0);
        run_conv(16'd54321, 1'b0, res, blk, lat, bcnt, dcnt);
        check("after_reset_bcd", 32'(res), 32'h54321);
        check("after_reset_done_count", 32'(dcnt), 32'd1);

        // Random values against the arithmetic model, plus output holding.
        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 65535));
            run_conv(16'(v), 1'b0, res, blk, lat, bcnt, dcnt);
            check($sformatf("rand%0d_bcd(%0d)", i, v), 32'(res), 32'(ref_bcd(v)));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd17);
`ifdef BCDCONV_LZB_EN
            check($sformatf("rand%0d_blank", i), 32'(blk), 32'(ref_blank(v)));
`endif
            held = ref_bcd(v);
            bin = 16'($urandom);
            repeat (3) @(negedge clk);
            check($sformatf("rand%0d_hold", i), 32'(bcd), 32'(held));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
